// File: rtl/mc_control_fsm_if.sv
// Control bundle between mc_control_fsm (master) and the datapath (slave):
// IR opcode and memory handshake toward the controller, datapath selects/enables back.
interface mc_control_fsm_if #(
  parameter int unsigned OPCODE_W = 6
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                pc_write;
  logic                pc_write_cond;
  logic                pc_write_cond_ne;
  logic                i_or_d;
  logic                mem_read;
  logic                mem_write;
  logic                mem_to_reg;
  logic                ir_write;
  logic                alu_src_a;
  logic                reg_write;
  logic                reg_dst;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic [1:0]          pc_source;
  logic [3:0]          state;
  logic                fault;
  logic                timeout;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, pc_write_cond_ne, i_or_d, mem_read, mem_write,
           mem_to_reg, ir_write, alu_src_a, reg_write, reg_dst,
           alu_src_b, alu_op, pc_source, state, fault, timeout
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, pc_write_cond_ne, i_or_d, mem_read, mem_write,
           mem_to_reg, ir_write, alu_src_a, reg_write, reg_dst,
           alu_src_b, alu_op, pc_source, state, fault, timeout
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-subset control unit with memory wait states, stall timeout and sticky fault.
// Define MC_IMM_OPS_EN to add the ADDI/ORI execute/writeback states.
module mc_control_fsm #(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  mc_control_fsm_if.master bus
);

  localparam int unsigned CNT_W     = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam int unsigned WAIT_LAST = (MAX_WAIT == 0) ? 0 : MAX_WAIT - 1;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'h00);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'h02);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'h04);
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'h05);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'h23);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'h2B);
`ifdef MC_IMM_OPS_EN
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'h08);
  localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(6'h0D);
`endif

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
`ifdef MC_IMM_OPS_EN
    S_IMM_EXEC = 4'd10,
    S_IMM_WB   = 4'd11,
`endif
    S_FAULT    = 4'd15
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic               timeout_q, timeout_d;
  logic               mem_wait_c;
  logic               expire_c;

  // States that stall on the memory handshake and feed the timeout counter.
  assign mem_wait_c = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign expire_c   = (MAX_WAIT != 0) && mem_wait_c && !bus.mem_ready &&
                      (wait_q == CNT_W'(WAIT_LAST));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    timeout_d            = timeout_q;
    wait_d               = '0;
    bus.pc_write         = 1'b0;
    bus.pc_write_cond    = 1'b0;
    bus.pc_write_cond_ne = 1'b0;
    bus.i_or_d           = 1'b0;
    bus.mem_read         = 1'b0;
    bus.mem_write        = 1'b0;
    bus.mem_to_reg       = 1'b0;
    bus.ir_write         = 1'b0;
    bus.alu_src_a        = 1'b0;
    bus.reg_write        = 1'b0;
    bus.reg_dst          = 1'b0;
    bus.alu_src_b        = 2'b00;
    bus.alu_op           = 2'b00;
    bus.pc_source        = 2'b00;

    case (state_q)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        bus.alu_src_b = 2'b11;
        if (bus.opcode == OP_RTYPE) begin
          state_d = S_R_EXEC;
        end else if ((bus.opcode == OP_LW) || (bus.opcode == OP_SW)) begin
          state_d = S_MEM_ADDR;
        end else if ((bus.opcode == OP_BEQ) || (bus.opcode == OP_BNE)) begin
          state_d = S_BRANCH;
        end else if (bus.opcode == OP_J) begin
          state_d = S_JUMP;
`ifdef MC_IMM_OPS_EN
        end else if ((bus.opcode == OP_ADDI) || (bus.opcode == OP_ORI)) begin
          state_d = S_IMM_EXEC;
`endif
        end else begin
          state_d = S_FAULT;
        end
      end
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        if (bus.mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_R_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
        state_d       = S_R_WB;
      end
      S_R_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a        = 1'b1;
        bus.alu_op           = 2'b01;
        bus.pc_source        = 2'b01;
        bus.pc_write_cond    = (bus.opcode == OP_BEQ);
        bus.pc_write_cond_ne = (bus.opcode == OP_BNE);
        state_d              = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
        state_d       = S_FETCH;
      end
`ifdef MC_IMM_OPS_EN
      S_IMM_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_op    = (bus.opcode == OP_ORI) ? 2'b11 : 2'b00;
        state_d       = S_IMM_WB;
      end
      S_IMM_WB: begin
        bus.reg_write = 1'b1;
        state_d       = S_FETCH;
      end
`endif
      // FAULT is absorbing; unused encodings fall into it as well.
      default: state_d = S_FAULT;
    endcase

    if (expire_c) begin
      state_d   = S_FAULT;
      timeout_d = 1'b1;
    end

    // Count consecutive not-ready cycles within one stalled state only.
    if ((MAX_WAIT != 0) && mem_wait_c && !bus.mem_ready && (state_d == state_q)) begin
      wait_d = wait_q + CNT_W'(1);
    end
  end

  assign bus.state   = state_q;
  assign bus.fault   = (state_q == S_FAULT);
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized instruction-level bench for mc_control_fsm: expected state/control
// traces are planned per instruction from opcode and memory wait counts.
module tb_mc_control_fsm;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned MAX_WAIT = 15;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MADDR = 2, ST_MRD = 3, ST_MWB = 4, ST_MWR = 5;
  localparam int ST_REX = 6, ST_RWB = 7, ST_BR = 8, ST_J = 9, ST_IEX = 10, ST_IWB = 11, ST_FAULT = 15;

  typedef enum int {K_R, K_LW, K_SW, K_BR, K_J, K_IMM, K_BAD} kind_e;

  typedef struct {
    int st;
    bit mr;
    bit to;
  } step_t;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;
  step_t plan[$];
  logic [5:0] op_tab [10] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0D, 6'h3F, 6'h00};

  always #5 clk = ~clk;

  mc_control_fsm_if #(.OPCODE_W(OPCODE_W)) bus ();

  mc_control_fsm #(.OPCODE_W(OPCODE_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic kind_e classify(input logic [5:0] op);
    case (op)
      6'h00: return K_R;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h04, 6'h05: return K_BR;
      6'h02: return K_J;
`ifdef MC_IMM_OPS_EN
      6'h08, 6'h0D: return K_IMM;
`endif
      default: return K_BAD;
    endcase
  endfunction

  // Expected control word per state, straight from the state table.
  function automatic logic [16:0] exp_ctrl(input int st, input logic [5:0] op, input logic mr);
    logic pcw = 0, pcc = 0, pcn = 0, iod = 0, mrd = 0, mwr = 0, m2r = 0;
    logic irw = 0, asa = 0, rw = 0, rd = 0;
    logic [1:0] asb = 0, aop = 0, psrc = 0;
    case (st)
      ST_FETCH:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      ST_DECODE: asb = 2'b11;
      ST_MADDR:  begin asa = 1; asb = 2'b10; end
      ST_MRD:    begin mrd = 1; iod = 1; end
      ST_MWB:    begin rw = 1; m2r = 1; end
      ST_MWR:    begin mwr = 1; iod = 1; end
      ST_REX:    begin asa = 1; aop = 2'b10; end
      ST_RWB:    begin rw = 1; rd = 1; end
      ST_BR:     begin asa = 1; aop = 2'b01; psrc = 2'b01; pcc = (op == 6'h04); pcn = (op == 6'h05); end
      ST_J:      begin pcw = 1; psrc = 2'b10; end
      ST_IEX:    begin asa = 1; asb = 2'b10; aop = (op == 6'h0D) ? 2'b11 : 2'b00; end
      ST_IWB:    rw = 1;
      default:   ;
    endcase
    return {pcw, pcc, pcn, iod, mrd, mwr, m2r, irw, asa, rw, rd, asb, aop, psrc};
  endfunction

  function automatic logic [16:0] dut_ctrl();
    return {bus.pc_write, bus.pc_write_cond, bus.pc_write_cond_ne, bus.i_or_d, bus.mem_read,
            bus.mem_write, bus.mem_to_reg, bus.ir_write, bus.alu_src_a, bus.reg_write,
            bus.reg_dst, bus.alu_src_b, bus.alu_op, bus.pc_source};
  endfunction

  function automatic void push_any(input int st);
    step_t s;
    s.st = st; s.mr = 1'($urandom); s.to = 1'b0;
    plan.push_back(s);
  endfunction

  function automatic void push_fault(input bit to);
    step_t s;
    for (int i = 0; i < 3; i++) begin
      s.st = ST_FAULT; s.mr = 1'($urandom); s.to = to;
      plan.push_back(s);
    end
  endfunction

  // w not-ready cycles then ready; MAX_WAIT or more not-ready cycles end in a timeout fault.
  function automatic bit push_wait(input int st, input int w);
    step_t s;
    s.st = st; s.mr = 1'b0; s.to = 1'b0;
    if (w >= int'(MAX_WAIT)) begin
      for (int i = 0; i < int'(MAX_WAIT); i++) plan.push_back(s);
      push_fault(1'b1);
      return 1'b1;
    end
    for (int i = 0; i < w; i++) plan.push_back(s);
    s.mr = 1'b1;
    plan.push_back(s);
    return 1'b0;
  endfunction

  function automatic void build(input logic [5:0] op, input int fw, input int mw);
    plan.delete();
    if (push_wait(ST_FETCH, fw)) return;
    push_any(ST_DECODE);
    case (classify(op))
      K_R:   begin push_any(ST_REX); push_any(ST_RWB); end
      K_LW:  begin push_any(ST_MADDR); if (!push_wait(ST_MRD, mw)) push_any(ST_MWB); end
      K_SW:  begin push_any(ST_MADDR); void'(push_wait(ST_MWR, mw)); end
      K_BR:  push_any(ST_BR);
      K_J:   push_any(ST_J);
      K_IMM: begin push_any(ST_IEX); push_any(ST_IWB); end
      default: push_fault(1'b0);
    endcase
  endfunction

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_plan(input logic [5:0] op);
    foreach (plan[i]) begin
      bus.mem_ready = plan[i].mr;
      bus.opcode    = (plan[i].st == ST_FETCH) ? 6'($urandom) : op;
      #1;
      check($sformatf("state op=%0h i=%0d", op, i), 32'(bus.state), 32'(plan[i].st));
      check($sformatf("ctrl op=%0h i=%0d st=%0d", op, i, plan[i].st), 32'(dut_ctrl()),
            32'(exp_ctrl(plan[i].st, op, plan[i].mr)));
      check($sformatf("fault op=%0h i=%0d", op, i), 32'(bus.fault), 32'(plan[i].st == ST_FAULT));
      check($sformatf("timeout op=%0h i=%0d", op, i), 32'(bus.timeout), 32'(plan[i].to));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_state", 32'(bus.state), 32'(ST_FETCH));
    check("rst_fault", 32'(bus.fault), 32'd0);
    check("rst_timeout", 32'(bus.timeout), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    build(op, fw, mw);
    run_plan(op);
    if (plan[plan.size() - 1].st == ST_FAULT) do_reset();
  endtask

  initial begin
    step_t s;
    reset         = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode    = 6'h00;
    #2;
    check("rst_state0", 32'(bus.state), 32'(ST_FETCH));
    check("rst_ctrl0", 32'(dut_ctrl()), 32'(exp_ctrl(ST_FETCH, 6'h00, 1'b1)));
    check("rst_fault0", 32'(bus.fault), 32'd0);
    check("rst_timeout0", 32'(bus.timeout), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    run_instr(6'h00, 0, 0);
    run_instr(6'h23, 0, 3);
    run_instr(6'h05, 0, 0);
    run_instr(6'h04, 2, 0);
    run_instr(6'h2B, 1, 2);
    run_instr(6'h02, 0, 0);
    run_instr(6'h00, 15, 0);
    run_instr(6'h00, 14, 0);
    run_instr(6'h23, 0, 14);
    run_instr(6'h2B, 0, 15);
    run_instr(6'h3F, 0, 0);
    run_instr(6'h08, 0, 0);
    run_instr(6'h0D, 1, 0);

    // Reset while stalled in MEM_WR must drop mem_write immediately.
    plan.delete();
    s.st = ST_FETCH; s.mr = 1'b1; s.to = 1'b0; plan.push_back(s);
    push_any(ST_DECODE);
    push_any(ST_MADDR);
    s.st = ST_MWR; s.mr = 1'b0; plan.push_back(s);
    run_plan(6'h2B);
    bus.mem_ready = 1'b0;
    #1;
    check("mwr_pre", 32'(bus.mem_write), 32'd1);
    reset = 1'b0;
    #1;
    check("mwr_async", 32'(bus.mem_write), 32'd0);
    check("mwr_state", 32'(bus.state), 32'(ST_FETCH));
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int n = 0; n < 150; n++) begin
      int idx, fw, mw;
      logic [5:0] op;
      idx = int'($urandom_range(9, 0));
      op  = (idx == 9) ? 6'($urandom) : op_tab[idx];
      fw  = ($urandom_range(7, 0) == 0) ? int'($urandom_range(MAX_WAIT + 2, MAX_WAIT - 1))
                                        : int'($urandom_range(3, 0));
      mw  = ($urandom_range(5, 0) == 0) ? int'($urandom_range(MAX_WAIT + 2, MAX_WAIT - 1))
                                        : int'($urandom_range(4, 0));
      run_instr(op, fw, mw);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Parametrised multicycle control unit for the single-bus MIPS-subset core: decodes the IR opcode and sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK, driving every datapath select and enable.
- Successor to the fixed-cycle control unit: adds memory wait-state handshaking, a stall timeout, BNE support and a sticky fault state for illegal opcodes.
- Optional I-type arithmetic is compiled in by macro.
- Sits beside `datapath` at top level; clock is the board 50 MHz net.

## Interface
- OPCODE_W, 6, opcode width (≥6); opcode constants are zero-extended to this width.
- MAX_WAIT, 15, consecutive not-ready memory cycles tolerated before fault; 0 disables the timeout.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  OPCODE_W  IR[31:26], stable from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write, pc_write_cond, pc_write_cond_ne, i_or_d, mem_read, mem_write, mem_to_reg, ir_write, alu_src_a, reg_write, reg_dst  out  1 each  datapath controls.
- alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded, 11 OR.
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- state  out  4  current state encoding, for debug.
- fault  out  1  sticky; high while in FAULT.
- timeout  out  1  sticky; set together with fault when the stall timeout caused it.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, IMM_EXEC 10, IMM_WB 11, FAULT 15.
- Any control output not listed for a state is 0.
- FETCH: mem_read=1, alu_src_b=01.
  - ir_write and pc_write equal mem_ready. This is the only Mealy term.
  - Holds FETCH until mem_ready=1, then goes to DECODE.
- DECODE: alu_src_b=11. Next state by opcode:
  - 0x00 → R_EXEC
  - 0x23 LW and 0x2B SW → MEM_ADDR
  - 0x04 BEQ and 0x05 BNE → BRANCH
  - 0x02 J → JUMP
  - 0x08 ADDI and 0x0D ORI → IMM_EXEC (only when the macro is defined)
  - anything else → FAULT
- MEM_ADDR: alu_src_a=1, alu_src_b=10. Goes to MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1. Then FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready, then FETCH.
- R_EXEC: alu_src_a=1, alu_op=10. Then R_WB.
- R_WB: reg_write=1, reg_dst=1. Then FETCH.
- BRANCH: alu_src_a=1, alu_op=01, pc_source=01.
  - pc_write_cond=1 for BEQ; pc_write_cond_ne=1 for BNE.
  - Then FETCH.
- JUMP: pc_write=1, pc_source=10. Then FETCH.
- IMM_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 for ADDI, 11 for ORI. Then IMM_WB.
- IMM_WB: reg_write=1. Then FETCH.
- FAULT: all controls 0, fault=1. Absorbing; only reset leaves it.
- Wait counter, width $clog2(MAX_WAIT+1):
  - Increments in FETCH/MEM_RD/MEM_WR on each cycle with mem_ready=0.
  - Clears on any cycle with mem_ready=1 and on any state change.
  - If mem_ready=0 and count==MAX_WAIT-1: next state FAULT, timeout=1.
  - Hence exactly MAX_WAIT not-ready cycles trigger the fault.
  - mem_ready=1 in the same cycle the counter would expire wins: normal progress, no fault.

## Timing
- Reset (asynchronous assert):
  - state=FETCH, counter=0, fault=0, timeout=0.
  - Outputs immediately: mem_read=1, alu_src_b=01, ir_write=pc_write=mem_ready, all others 0.
- Reset assertion mid-instruction aborts it; no partial write is held. Deassertion is sampled on the next rising edge.
- Zero-wait cycles per instruction: R 4, LW 5, SW 4, BEQ/BNE 3, J 3, ADDI/ORI 4. Each memory wait cycle adds one.
- Outputs other than the FETCH Mealy terms are registered-state decodes, valid the whole cycle.

## Configuration
- MC_IMM_OPS_EN defined: ADDI/ORI decode to IMM_EXEC/IMM_WB.
- MC_IMM_OPS_EN undefined: states 10/11 are not generated; opcodes 0x08/0x0D go to FAULT like any illegal opcode.

## Test plan
- Reset with mem_ready=1, opcode=0x00 → state sequence 0,1,6,7,0; reg_write=1 and reg_dst=1 only in state 7; 4 cycles total.
- LW (0x23) with mem_ready low 3 cycles in MEM_RD → sequence 0,1,2,3,3,3,3,4,0; mem_to_reg=1 in state 4; no fault.
- BNE (0x05) → in state 8, pc_write_cond_ne=1, pc_write_cond=0, alu_op=01, pc_source=01; returns to FETCH after 3 cycles.
- MAX_WAIT=15, mem_ready held 0 in FETCH → FAULT after exactly 15 cycles, fault=timeout=1, ir_write never pulses; second run with mem_ready=1 on cycle 15 → DECODE, no fault.
- Opcode 0x3F → FAULT from DECODE, fault=1, timeout=0, all controls 0 until reset.
- ADDI (0x08) → with the macro, states 0,1,10,11,0 with alu_op=00 in state 10; without it, FAULT.
- Reset asserted while in MEM_WR → mem_write drops immediately (asynchronously), state=0.
